// File: rtl/teclado_escaner_antirrebote_if.sv
// Keypad scanner bundle: matrix row/column pads
// and the debounced key code handed downstream.
interface teclado_escaner_antirrebote_if;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;

  modport master (
    output filas,
    output key_value,
    output key_valid,
    output key_held,
    input  columnas
  );

  modport slave (
    input  filas,
    input  key_value,
    input  key_valid,
    input  key_held,
    output columnas
  );
endinterface

// File: rtl/teclado_escaner_antirrebote.sv
// 4x4 keypad scanner with column synchroniser,
// press/release debounce and one strobe per press.
module teclado_escaner_antirrebote #(
  parameter int SCAN_DIV  = 27000,
  parameter int DEB_COUNT = 20
) (
  input logic clk,
  input logic rst_n,
  teclado_escaner_antirrebote_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    SCAN, DEBOUNCE, HELD, RELEASE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] col_m, col_s;
  logic [DW-1:0] div_q;
  logic [1:0] row_q, row_d;
  logic [1:0] cidx_q, cidx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] kv_q, kv_d;
  logic       vld_q, vld_d;
  logic       held_q, held_d;
  logic       tick;
  logic [3:0] inv;
  logic       one_low;
  logic [1:0] col_enc;
  logic [3:0] pat;

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'hE;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      div_q <= '0;
    end else begin
      col_m <= kp.columnas;
      col_s <= col_m;
      div_q <= tick ? '0 : div_q + DW'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);
  assign inv  = ~col_s;
  // Exactly one column low: nonzero and a power of two.
  assign one_low = (inv != 4'd0) &&
                   ((inv & (inv - 4'd1)) == 4'd0);
  assign pat = ~(4'b0001 << cidx_q);

  always_comb begin
    case (inv)
      4'b0010: col_enc = 2'd1;
      4'b0100: col_enc = 2'd2;
      4'b1000: col_enc = 2'd3;
      default: col_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cidx_d  = cidx_q;
    cnt_d   = cnt_q;
    kv_d    = kv_q;
    vld_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low) begin
            cidx_d = col_enc;
            cnt_d  = CNT_ONE;
            if (CNT_LAST == '0) begin
              state_d = HELD;
              kv_d    = key_code(row_q, col_enc);
              vld_d   = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s == pat) begin
            if (cnt_q == CNT_LAST) begin
              state_d = HELD;
              kv_d    = key_code(row_q, cidx_q);
              vld_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        HELD: begin
          if (col_s == 4'hF) begin
            cnt_d = CNT_ONE;
            if (CNT_LAST == '0) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (col_s == 4'hF) begin
            if (cnt_q == CNT_LAST) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
    held_d = (state_d == HELD) ||
             (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      cidx_q  <= 2'd0;
      cnt_q   <= '0;
      kv_q    <= 4'h0;
      vld_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cidx_q  <= cidx_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      vld_q   <= vld_d;
      held_q  <= held_d;
    end
  end

  assign kp.filas     = ~(4'b0001 << row_q);
  assign kp.key_value = kv_q;
  assign kp.key_valid = vld_q;
  assign kp.key_held  = held_q;

endmodule

// File: doc/teclado_escaner_antirrebote.md
Name: teclado_escaner_antirrebote

Overview:
- Upstream stage of the keypad-driven adder. Scans the 4x4 matrix keypad, synchronises and debounces the column inputs, and encodes each press into a 4-bit key code.
- Delivers that code with a single-cycle valid strobe to the entry FSM that loads the A/B operands.
- One strobe per physical press; auto-repeat is never generated.

Parameters:
- SCAN_DIV, 27000, clock cycles per row dwell and per debounce sample (1 ms at 27 MHz); legal range >= 4.
- DEB_COUNT, 20, consecutive matching samples required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst_n  input  1  reset; see interface decision below.
- Interface decision: one clock; reset is asynchronous and active-low.
- filas  output  4  row drive, active-low one-hot; exactly one bit low at all times.
- columnas  input  4  column sense, active-low (pull-ups on board), asynchronous to clk.
- key_value  output  4  code of the last accepted key; held until the next accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while an accepted key is still pressed (until release is debounced).

Behaviour:
- Reset values: filas=4'b1110 (row 0), key_value=0, key_valid=0, key_held=0. All counters and the FSM return to SCAN/row 0.
- Reset mid-operation aborts any debounce silently: no key_valid is emitted.
- Synchroniser: columnas passes through 2 flops (col_s). All decisions use col_s only.
- Tick: a divider counts 0..SCAN_DIV-1. "tick" is the cycle where the count equals SCAN_DIV-1. The divider free-runs and is cleared only by reset.
- Key map, written as row r / col c -> code:
  - r0: c0=1, c1=2, c2=3, c3=A.
  - r1: c0=4, c1=5, c2=6, c3=B.
  - r2: c0=7, c1=8, c2=9, c3=C.
  - r3: c0=E(*), c1=0, c2=F(#), c3=D.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On each tick, sample col_s.
  - If exactly one bit is low: capture row index and column index, set match count to 1, go to DEBOUNCE. filas stays frozen on the captured row.
  - Otherwise (no key, or two or more columns low): advance filas to the next row, wrapping 3 -> 0.
- DEBOUNCE:
  - On each tick, compare col_s with the captured one-hot pattern.
  - Match: increment match count. When it reaches DEB_COUNT, go to HELD, load key_value, and pulse key_valid for exactly 1 cycle (the cycle after that tick).
  - Mismatch (release, bounce, or a different or extra column): go to SCAN, advance to the next row, no strobe.
  - DEB_COUNT=1: the strobe follows the capturing tick directly (SCAN to HELD in one step).
- HELD:
  - key_held=1; filas stays frozen.
  - On each tick, if col_s==4'b1111, set release count to 1 and go to RELEASE. Any other value keeps the state.
  - Additional keys pressed in other rows are ignored.
- RELEASE:
  - key_held=1.
  - On each tick, col_s==4'b1111 increments release count; any low bit returns to HELD with no new strobe.
  - When release count reaches DEB_COUNT: key_held=0, go to SCAN, advance to the next row.
- Latency: accepted press strobe comes (DEB_COUNT-1)*SCAN_DIV+1 cycles after the capturing tick, plus 2 synchroniser cycles from the pad.
- key_valid and key_held are registered outputs. key_valid is never high on two consecutive cycles.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEB_COUNT+1). Counters must not wrap.

Test Plan (SCAN_DIV=4, DEB_COUNT=3):
- Reset, columnas=4'hF for 64 cycles -> filas cycles 1110,1101,1011,0111,1110, changing every 4 cycles; key_valid never high; key_value=0.
- Hold col1 low whenever filas=1011 (key 8), stable -> filas freezes at 1011. key_valid pulses once with key_value=4'h8 after 3 matching ticks. key_held=1 until 3 clean release ticks, then scanning resumes at 0111.
- Press key 5 bouncing low/high on alternate ticks for 40 cycles, then stable -> no strobe during the bounce; exactly one strobe (key_value=4'h5) after 3 stable ticks.
- In row 0, drive col0 and col3 low together -> no capture, scanning continues, no strobe. Then release col3 -> key 1 accepted, key_value=4'h1.
- Hold # (r3, c2) for 200 cycles -> exactly one strobe (code 4'hF); key_held high the whole time. A brief 1-tick release glitch mid-hold produces no second strobe.
- Assert rst_n low in DEBOUNCE after 2 matching ticks of key 3 -> outputs return to reset values immediately, asynchronously. After rst_n rises with the key still held, a fresh full debounce runs before any strobe.
